// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
//   Writeback stage of the 3-stage core and write-side initiator of the
//   register file. It accepts completed instructions from execute through a
//   valid/ready handshake. ALU/jump results go to the write port one cycle
//   after acceptance. A load parks the stage in WAIT_LOAD until the
//   data-memory response arrives. The response is then aligned,
//   sign/zero-extended and written one cycle later.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   : byp_* mirror the registered write port. In the mem_rvalid
//                 cycle they instead carry the aligned load data
//                 combinationally, for same-cycle forwarding into execute.
//     undefined : byp_* are tied to 0.
//
// Ports
//   clk, reset_n             core clock (rising edge), synchronous active-low reset
//   ex_valid / ex_ready      execute handshake
//   ex_regwen, ex_rd         write intent and destination register
//   ex_result                ALU/jump result (ignored for loads)
//   ex_is_load, ex_funct3,
//   ex_addr_lo               load marker, width/sign and byte offset
//   mem_rvalid, mem_rdata    single-cycle load response and raw word
//   rd_addr, wdata, RegWEn   registered register-file write port
//   pend_valid, pend_rd      outstanding-load info for hazard detection
//   byp_valid/rd/data        bypass port (WB_BYPASS_EN only)
//   spurious_rsp             sticky: response seen with no load pending
// -----------------------------------------------------------------------------
module wb_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_regwen,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_funct3,
    input  logic [1:0]  ex_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rd_addr,
    output logic [31:0] wdata,
    output logic        RegWEn,
    output logic        pend_valid,
    output logic [4:0]  pend_rd,
    output logic        byp_valid,
    output logic [4:0]  byp_rd,
    output logic [31:0] byp_data,
    output logic        spurious_rsp
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t      state_q, state_d;

    // Load context captured at acceptance
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic        ld_regwen_q, ld_regwen_d;
    logic [2:0]  ld_funct3_q, ld_funct3_d;
    logic [1:0]  ld_addr_lo_q, ld_addr_lo_d;

    // Registered write port
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        regwen_q, regwen_d;
    logic        spurious_q, spurious_d;

    logic        load_done;
    logic        load_we;
    logic [31:0] load_data;

    // Select the addressed byte/half and extend to XLEN. Half selection
    // uses only lo[1]; word loads ignore lo entirely. Unlisted funct3
    // codes fall back to a full-word load.
    function automatic logic [31:0] load_align(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lo);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [31:0]        res;
        byte_s = word[{lo, 3'b000} +: 8];
        half_s = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{byte_s[7]}}, byte_s};
            3'b001:  res = {{16{half_s[15]}}, half_s};
            3'b100:  res = {24'd0, byte_s};
            3'b101:  res = {16'd0, half_s};
            default: res = word;
        endcase
        return res;
    endfunction

    assign load_done = (state_q == WAIT_LOAD) && mem_rvalid;
    assign load_we   = ld_regwen_q && (ld_rd_q != 5'd0);
    assign load_data = load_align(mem_rdata, ld_funct3_q, ld_addr_lo_q);

    always_comb begin
        state_d      = state_q;
        ld_rd_d      = ld_rd_q;
        ld_regwen_d  = ld_regwen_q;
        ld_funct3_d  = ld_funct3_q;
        ld_addr_lo_d = ld_addr_lo_q;
        rd_addr_d    = rd_addr_q;
        wdata_d      = wdata_q;
        regwen_d     = 1'b0;
        spurious_d   = spurious_q;
        ex_ready     = 1'b0;

        case (state_q)
            IDLE: begin
                ex_ready = 1'b1;
                // A response with nothing outstanding is dropped and flagged.
                if (mem_rvalid) begin
                    spurious_d = 1'b1;
                end
                if (ex_valid) begin
                    if (ex_is_load) begin
                        ld_rd_d      = ex_rd;
                        ld_regwen_d  = ex_regwen;
                        ld_funct3_d  = ex_funct3;
                        ld_addr_lo_d = ex_addr_lo;
                        state_d      = WAIT_LOAD;
                    end else begin
                        // x0 completes normally but never asserts the write.
                        rd_addr_d = ex_rd;
                        wdata_d   = ex_result;
                        regwen_d  = ex_regwen && (ex_rd != 5'd0);
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    rd_addr_d = ld_rd_q;
                    wdata_d   = load_data;
                    regwen_d  = load_we;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ld_rd_q      <= 5'd0;
            ld_regwen_q  <= 1'b0;
            ld_funct3_q  <= 3'd0;
            ld_addr_lo_q <= 2'd0;
            rd_addr_q    <= 5'd0;
            wdata_q      <= 32'd0;
            regwen_q     <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_rd_q      <= ld_rd_d;
            ld_regwen_q  <= ld_regwen_d;
            ld_funct3_q  <= ld_funct3_d;
            ld_addr_lo_q <= ld_addr_lo_d;
            rd_addr_q    <= rd_addr_d;
            wdata_q      <= wdata_d;
            regwen_q     <= regwen_d;
            spurious_q   <= spurious_d;
        end
    end

    assign rd_addr      = rd_addr_q;
    assign wdata        = wdata_q;
    assign RegWEn       = regwen_q;
    assign spurious_rsp = spurious_q;

    // Pending drops in the response cycle so hazard logic can release
    // the dependent instruction as soon as the data is known.
    assign pend_valid = (state_q == WAIT_LOAD) && !mem_rvalid;
    assign pend_rd    = pend_valid ? ld_rd_q : 5'd0;

`ifdef WB_BYPASS_EN
    always_comb begin
        if (load_done) begin
            byp_valid = load_we;
            byp_rd    = ld_rd_q;
            byp_data  = load_data;
        end else begin
            byp_valid = regwen_q;
            byp_rd    = rd_addr_q;
            byp_data  = wdata_q;
        end
    end
`else
    assign byp_valid = 1'b0;
    assign byp_rd    = 5'd0;
    assign byp_data  = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
//   Directed testbench for wb_stage: reset inside WAIT_LOAD, ALU stream,
//   load alignment, stall behaviour, back-to-back loads, bypass port and
//   spurious-response flag.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk;
    logic        reset_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_regwen;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] wdata;
    logic        RegWEn;
    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;
    logic        spurious_rsp;

    int total;
    int bad;

    wb_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_regwen    (ex_regwen),
        .ex_rd        (ex_rd),
        .ex_result    (ex_result),
        .ex_is_load   (ex_is_load),
        .ex_funct3    (ex_funct3),
        .ex_addr_lo   (ex_addr_lo),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .rd_addr      (rd_addr),
        .wdata        (wdata),
        .RegWEn       (RegWEn),
        .pend_valid   (pend_valid),
        .pend_rd      (pend_rd),
        .byp_valid    (byp_valid),
        .byp_rd       (byp_rd),
        .byp_data     (byp_data),
        .spurious_rsp (spurious_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
        ex_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_regwen  = 1'b1;
        ex_rd      = rd;
        ex_funct3  = f3;
        ex_addr_lo = lo;
        ex_result  = 32'hCAFE_0000;
    endtask

    task automatic drive_alu(input logic we, input logic [4:0] rd, input logic [31:0] res);
        ex_valid   = 1'b1;
        ex_is_load = 1'b0;
        ex_regwen  = we;
        ex_rd      = rd;
        ex_result  = res;
        ex_funct3  = 3'd0;
        ex_addr_lo = 2'd0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        drive_load(5'd6, 3'b010, 2'd0);
        step();
        ex_valid = 1'b0;
        total++; if (pend_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_pend got=%0b exp=1", pend_valid); end
        reset_n = 1'b0;
        step();
        step();
        total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL rst_ex_ready got=%0b exp=1", ex_ready); end
        total++; if (pend_valid !== 1'b0 || pend_rd !== 5'd0) begin bad++; $display("FAIL rst_pend got=%0b/%0d exp=0/0", pend_valid, pend_rd); end
        total++; if (RegWEn !== 1'b0 || rd_addr !== 5'd0 || wdata !== 32'd0) begin bad++; $display("FAIL rst_wport got=%0b/%0d/%0h exp=0/0/0", RegWEn, rd_addr, wdata); end
        total++; if (byp_valid !== 1'b0 || byp_rd !== 5'd0 || byp_data !== 32'd0) begin bad++; $display("FAIL rst_byp got=%0b/%0d/%0h exp=0/0/0", byp_valid, byp_rd, byp_data); end
        total++; if (spurious_rsp !== 1'b0) begin bad++; $display("FAIL rst_spurious got=%0b exp=0", spurious_rsp); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_alu_stream();
        drive_alu(1'b1, 5'd5, 32'h11);
        #1;
        total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL alu_ready0 got=%0b exp=1", ex_ready); end
        step();
        total++; if (RegWEn !== 1'b1 || rd_addr !== 5'd5 || wdata !== 32'h11) begin bad++; $display("FAIL alu_w1 got=%0b/%0d/%0h exp=1/5/11", RegWEn, rd_addr, wdata); end
        drive_alu(1'b1, 5'd0, 32'h22);
        #1;
        total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL alu_ready1 got=%0b exp=1", ex_ready); end
        step();
        total++; if (RegWEn !== 1'b0) begin bad++; $display("FAIL alu_w_x0 got=%0b exp=0", RegWEn); end
        drive_alu(1'b1, 5'd7, 32'h33);
        #1;
        total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL alu_ready2 got=%0b exp=1", ex_ready); end
        step();
        total++; if (RegWEn !== 1'b1 || rd_addr !== 5'd7 || wdata !== 32'h33) begin bad++; $display("FAIL alu_w3 got=%0b/%0d/%0h exp=1/7/33", RegWEn, rd_addr, wdata); end
        ex_valid = 1'b0;
        step();
        total++; if (RegWEn !== 1'b0) begin bad++; $display("FAIL alu_pulse_end got=%0b exp=0", RegWEn); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [7];
        logic [1:0]  lo  [7];
        logic [31:0] exp [7];
        f3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001};
        lo  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1};
        exp = '{32'hFFFF_FF82, 32'h0000_007F, 32'hFFFF_80F1, 32'h0000_80F1,
                32'h80F1_7F82, 32'hFFFF_FF80, 32'h0000_7F82};
        for (int i = 0; i < 7; i++) begin
            drive_load(5'(10 + i), f3[i], lo[i]);
            step();
            ex_valid = 1'b0;
            #1;
            total++; if (pend_valid !== 1'b1 || pend_rd !== 5'(10 + i) || ex_ready !== 1'b0) begin bad++; $display("FAIL load%0d_pend got=%0b/%0d/%0b exp=1/%0d/0", i, pend_valid, pend_rd, ex_ready, 10 + i); end
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h80F1_7F82;
            #1;
            total++; if (pend_valid !== 1'b0) begin bad++; $display("FAIL load%0d_pend_drop got=%0b exp=0", i, pend_valid); end
            step();
            mem_rvalid = 1'b0;
            total++; if (RegWEn !== 1'b1 || rd_addr !== 5'(10 + i) || wdata !== exp[i]) begin bad++; $display("FAIL load%0d_w got=%0b/%0d/%h exp=1/%0d/%h", i, RegWEn, rd_addr, wdata, 10 + i, exp[i]); end
            step();
        end
    endtask

    task automatic test_stall();
        drive_load(5'd9, 3'b010, 2'd0);
        step();
        drive_alu(1'b1, 5'd4, 32'hAB);
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (ex_ready !== 1'b0 || pend_valid !== 1'b1 || pend_rd !== 5'd9 || RegWEn !== 1'b0) begin bad++; $display("FAIL stall%0d got=rdy%0b pend%0b/%0d we%0b exp=rdy0 pend1/9 we0", k, ex_ready, pend_valid, pend_rd, RegWEn); end
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #1;
        total++; if (ex_ready !== 1'b0) begin bad++; $display("FAIL stall_rsp_ready got=%0b exp=0", ex_ready); end
        step();
        mem_rvalid = 1'b0;
        #1;
        total++; if (RegWEn !== 1'b1 || rd_addr !== 5'd9 || wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL stall_load_w got=%0b/%0d/%h exp=1/9/deadbeef", RegWEn, rd_addr, wdata); end
        total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%0b exp=1", ex_ready); end
        step();
        ex_valid = 1'b0;
        total++; if (RegWEn !== 1'b1 || rd_addr !== 5'd4 || wdata !== 32'hAB) begin bad++; $display("FAIL stall_next_w got=%0b/%0d/%h exp=1/4/ab", RegWEn, rd_addr, wdata); end
        step();
        total++; if (RegWEn !== 1'b0) begin bad++; $display("FAIL stall_pulse_end got=%0b exp=0", RegWEn); end
    endtask

    task automatic test_back_to_back();
        drive_load(5'd12, 3'b100, 2'd0);
        step();
        drive_load(5'd13, 3'b010, 2'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_00A5;
        #1;
        total++; if (ex_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_rsp got=%0b exp=0", ex_ready); end
        step();
        mem_rvalid = 1'b0;
        #1;
        total++; if (RegWEn !== 1'b1 || rd_addr !== 5'd12 || wdata !== 32'hA5) begin bad++; $display("FAIL b2b_w0 got=%0b/%0d/%h exp=1/12/a5", RegWEn, rd_addr, wdata); end
        total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b exp=1", ex_ready); end
        step();
        ex_valid = 1'b0;
        total++; if (pend_valid !== 1'b1 || pend_rd !== 5'd13 || RegWEn !== 1'b0) begin bad++; $display("FAIL b2b_pend got=%0b/%0d we%0b exp=1/13 we0", pend_valid, pend_rd, RegWEn); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        total++; if (RegWEn !== 1'b1 || rd_addr !== 5'd13 || wdata !== 32'h1234_5678) begin bad++; $display("FAIL b2b_w1 got=%0b/%0d/%h exp=1/13/12345678", RegWEn, rd_addr, wdata); end
        step();
    endtask

    task automatic test_bypass();
        drive_load(5'd3, 3'b010, 2'd0);
        step();
        ex_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_1234;
        #1;
`ifdef WB_BYPASS_EN
        total++; if (byp_valid !== 1'b1 || byp_rd !== 5'd3 || byp_data !== 32'h1234) begin bad++; $display("FAIL byp_comb got=%0b/%0d/%h exp=1/3/1234", byp_valid, byp_rd, byp_data); end
`else
        total++; if (byp_valid !== 1'b0 || byp_rd !== 5'd0 || byp_data !== 32'd0) begin bad++; $display("FAIL byp_off_comb got=%0b/%0d/%h exp=0/0/0", byp_valid, byp_rd, byp_data); end
`endif
        step();
        mem_rvalid = 1'b0;
        #1;
`ifdef WB_BYPASS_EN
        total++; if (byp_valid !== 1'b1 || byp_rd !== 5'd3 || byp_data !== 32'h1234) begin bad++; $display("FAIL byp_reg got=%0b/%0d/%h exp=1/3/1234", byp_valid, byp_rd, byp_data); end
`else
        total++; if (byp_valid !== 1'b0 || byp_rd !== 5'd0 || byp_data !== 32'd0) begin bad++; $display("FAIL byp_off_reg got=%0b/%0d/%h exp=0/0/0", byp_valid, byp_rd, byp_data); end
`endif
        total++; if (RegWEn !== 1'b1 || rd_addr !== 5'd3 || wdata !== 32'h1234) begin bad++; $display("FAIL byp_wport got=%0b/%0d/%h exp=1/3/1234", RegWEn, rd_addr, wdata); end
        step();
    endtask

    task automatic test_spurious();
        total++; if (spurious_rsp !== 1'b0) begin bad++; $display("FAIL spur_initial got=%0b exp=0", spurious_rsp); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        total++; if (RegWEn !== 1'b0) begin bad++; $display("FAIL spur_no_write got=%0b exp=0", RegWEn); end
        total++; if (spurious_rsp !== 1'b1) begin bad++; $display("FAIL spur_set got=%0b exp=1", spurious_rsp); end
        drive_alu(1'b1, 5'd2, 32'h77);
        step();
        ex_valid = 1'b0;
        step();
        total++; if (spurious_rsp !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%0b exp=1", spurious_rsp); end
        // Reset clears the flag; a response right after reset sets it again.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        total++; if (spurious_rsp !== 1'b0) begin bad++; $display("FAIL spur_reset got=%0b exp=0", spurious_rsp); end
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        total++; if (spurious_rsp !== 1'b1 || RegWEn !== 1'b0) begin bad++; $display("FAIL spur_post_reset got=%0b we%0b exp=1 we0", spurious_rsp, RegWEn); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        ex_valid   = 1'b0;
        ex_regwen  = 1'b0;
        ex_rd      = 5'd0;
        ex_result  = 32'd0;
        ex_is_load = 1'b0;
        ex_funct3  = 3'd0;
        ex_addr_lo = 2'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        #1;
        test_reset();
        test_alu_stream();
        test_loads();
        test_stall();
        test_back_to_back();
        test_bypass();
        test_spurious();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 3-stage core and the write-side initiator for the register file. It accepts completed instructions from execute through a valid/ready handshake. For loads, it waits for the data-memory read response, then aligns and extends the load data. It drives the register file write port (rd_addr, wdata, RegWEn) with a registered one-cycle write pulse, and it exposes pending-load and bypass information for hazard handling.

## Interface
- No parameters; XLEN is fixed at 32.

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage accepts it this cycle
- ex_regwen  in  1  instruction writes rd
- ex_rd  in  5  destination register
- ex_result  in  32  ALU/jump result (ignored for loads)
- ex_is_load  in  1  instruction is a load
- ex_funct3  in  3  load width/sign
- ex_addr_lo  in  2  load byte offset
- mem_rvalid  in  1  load data valid (single-cycle pulse)
- mem_rdata  in  32  raw aligned word from data memory
- rd_addr  out  5  register file write address
- wdata  out  32  register file write data
- RegWEn  out  1  register file write enable
- pend_valid  out  1  a load is outstanding
- pend_rd  out  5  rd of the outstanding load
- byp_valid  out  1  bypass data valid (WB_BYPASS_EN only)
- byp_rd  out  5  bypass register
- byp_data  out  32  bypass data
- spurious_rsp  out  1  sticky: mem_rvalid arrived with no load pending

## Operation
- FSM states: IDLE and WAIT_LOAD. ex_ready = (state == IDLE). An instruction is accepted when ex_valid && ex_ready.
- Accepted in IDLE with ex_is_load=0: next cycle, RegWEn = ex_regwen && (ex_rd != 0), rd_addr = ex_rd, wdata = ex_result. State stays IDLE.
- Accepted with ex_is_load=1: capture rd, regwen, funct3 and addr_lo, then go to WAIT_LOAD. pend_valid=1 and pend_rd=rd.
- In WAIT_LOAD with mem_rvalid=1: return to IDLE and register the aligned data to the write port on the next cycle.
  - RegWEn = regwen && rd != 0.
  - pend_valid drops in the same cycle as mem_rvalid; it is combinational from state and mem_rvalid.
- Load alignment: shift = addr_lo*8.
  - 000 LB: sign-extend byte[shift].
  - 001 LH: sign-extend half[addr_lo[1]*16].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other funct3 values are treated as LW.
  - addr_lo[0] is ignored for halfwords. addr_lo is ignored for words. Misalignment is detected upstream.
- mem_rvalid in IDLE: ignored, no write, and spurious_rsp is set. spurious_rsp is cleared only by reset.
- rd == 0 never produces RegWEn=1, but the instruction still completes and is not stalled.
- RegWEn is high for exactly one cycle per completing instruction that writes a register.

## Timing
- Reset (reset_n=0 at a clk edge): state=IDLE; rd_addr=0, wdata=0, RegWEn=0, pend_valid=0, pend_rd=0, byp_*=0, spurious_rsp=0.
- Reset while in WAIT_LOAD drops the pending load. A mem_rvalid in the first cycle after reset sets spurious_rsp.
- ALU latency: 1 cycle from acceptance to RegWEn. Throughput is 1 per cycle.
- Load latency: 1 cycle from mem_rvalid to RegWEn. ex_ready is low from the cycle after load acceptance through the mem_rvalid cycle.
- ex_valid together with mem_rvalid in WAIT_LOAD: ex is not accepted (ex_ready=0). It is accepted the following cycle.
- Back-to-back loads: the minimum spacing is acceptance, then mem_rvalid, then the next acceptance in the cycle after mem_rvalid.

## Configuration
- WB_BYPASS_EN defined:
  - byp_valid = RegWEn, byp_rd = rd_addr, byp_data = wdata, all registered and identical to the write port.
  - In addition, byp_valid/byp_data reflect the aligned load data combinationally in the mem_rvalid cycle, which allows same-cycle forwarding into execute.
- WB_BYPASS_EN undefined: byp_valid, byp_rd and byp_data are tied to 0 and no bypass logic is built.

## Test plan
- Reset: hold reset_n=0 for 2 cycles while in WAIT_LOAD -> all outputs 0, ex_ready=1, pend_valid=0.
- ALU stream: 3 back-to-back ALU results (rd=5/0x11, rd=0/0x22, rd=7/0x33) -> RegWEn pulses for rd 5 and 7 on consecutive cycles 1–3, with no write for rd 0. ex_ready stays 1.
- Loads: mem_rdata=0x80F1_7F82.
  - LB at addr_lo=0 -> 0xFFFF_FF82.
  - LBU at addr_lo=1 -> 0x0000_007F.
  - LH at addr_lo=2 -> 0xFFFF_80F1.
  - LHU at addr_lo=2 -> 0x0000_80F1.
  - LW -> 0x80F1_7F82.
  - Each is written 1 cycle after mem_rvalid.
- Stall: load rd=9, mem_rvalid 4 cycles later, ex_valid held high -> ex_ready=0 and pend_valid=1/pend_rd=9 throughout. Next instruction accepted the cycle after mem_rvalid.
- Spurious: mem_rvalid in IDLE -> no RegWEn, spurious_rsp=1 and stays set until reset.
- WB_BYPASS_EN built: load rd=3, mem_rvalid with data 0x1234 -> in that cycle byp_valid=1, byp_rd=3, byp_data=0x1234. Without the macro, byp_* stay 0.
